// File: rtl/uart_mem_responder.sv
// Memory-side end of the UART memory link: decodes command frames and does 32-bit RAM word reads/writes.
// Latency: RAM read issued 1 cycle after A3 is accepted; first tx_start 3 cycles after A3 at the earliest.
// Backpressure: none on rx (bytes arriving outside a receive state are dropped); tx waits for tx_busy=0.
//
// Ports: clk/rst (async, active-high); rx_data/rx_valid/rx_fault from the UART receiver;
//        tx_data/tx_start/tx_busy to the UART transmitter; mem_ce/mem_we/mem_be/mem_addr/mem_wdata/mem_rdata
//        to a synchronous RAM (read data one cycle after mem_ce); frame_err pulses on any frame abort.
// Build option: define WRITE_ACK_EN to have every write frame answered with a single 0xA5 byte.
module uart_mem_responder #(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_fault,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              frame_err
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_MEM_WR, S_MEM_RD, S_RD_WAIT, S_SEND, S_TX_WAIT
    } state_t;

    state_t          state, state_nxt;
    logic            cmd_wr;
    logic [3:0]      cmd_be;
    logic [31:0]     addr_sr;
    logic [31:0]     data_sr;
    logic [31:0]     tx_sr;
    logic [1:0]      byte_cnt;   // field byte index, reused as tx byte index
    logic [TO_W-1:0] to_cnt;
    logic            tx_hold;    // first TX_WAIT cycle: tx_busy not yet valid
    logic            err_nxt;
    logic            take_byte;
    logic            to_hit;
    logic            unused_addr_bits;

    // Byte address -> word address; high bits and byte offset alias away.
    assign mem_addr         = addr_sr[ADDR_W+1:2];
    assign mem_wdata        = data_sr;
    assign tx_data          = tx_sr[7:0];
    assign to_hit           = (to_cnt == TO_LAST);
    assign unused_addr_bits = ^{addr_sr[31:ADDR_W+2], addr_sr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        take_byte = 1'b0;
        tx_start  = 1'b0;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_fault || (rx_data[6:4] != 3'b000)) err_nxt = 1'b1;
                    else                                      state_nxt = S_ADDR;
                end
            end
            S_ADDR, S_DATA: begin
                if (rx_valid) begin
                    if (rx_fault) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        take_byte = 1'b1;
                        if (byte_cnt == 2'd3) begin
                            if (state == S_DATA) state_nxt = S_MEM_WR;
                            else                 state_nxt = cmd_wr ? S_DATA : S_MEM_RD;
                        end
                    end
                end else if (to_hit) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_MEM_WR: begin
                // An all-zero byte-enable write is a no-op on the RAM.
                mem_ce = |cmd_be;
                mem_we = 1'b1;
                mem_be = cmd_be;
`ifdef WRITE_ACK_EN
                state_nxt = S_SEND;
`else
                state_nxt = S_IDLE;
`endif
            end
            S_MEM_RD: begin
                mem_ce    = 1'b1;
                state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: state_nxt = S_SEND;
            S_SEND: begin
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    state_nxt = S_TX_WAIT;
                end
            end
            S_TX_WAIT: begin
                if (!tx_hold && !tx_busy) state_nxt = (byte_cnt == 2'd3) ? S_IDLE : S_SEND;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_wr    <= 1'b0;
            cmd_be    <= 4'h0;
            addr_sr   <= 32'h0;
            data_sr   <= 32'h0;
            tx_sr     <= 32'h0;
            byte_cnt  <= 2'd0;
            to_cnt    <= '0;
            tx_hold   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_nxt;
            case (state)
                S_IDLE: begin
                    byte_cnt <= 2'd0;
                    to_cnt   <= '0;
                    if (state_nxt == S_ADDR) begin
                        cmd_wr <= rx_data[7];
                        cmd_be <= rx_data[3:0];
                    end
                end
                S_ADDR, S_DATA: begin
                    if (take_byte) begin
                        to_cnt   <= '0;
                        byte_cnt <= byte_cnt + 2'd1;
                        // LSB first: shift in from the top so byte 0 ends at [7:0].
                        if (state == S_ADDR) addr_sr <= {rx_data, addr_sr[31:8]};
                        else                 data_sr <= {rx_data, data_sr[31:8]};
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_MEM_WR: begin
`ifdef WRITE_ACK_EN
                    // Single ack byte: start the byte index at the last slot.
                    tx_sr    <= 32'h0000_00A5;
                    byte_cnt <= 2'd3;
`endif
                end
                S_RD_WAIT: tx_sr <= mem_rdata;
                S_SEND:    tx_hold <= !tx_busy;
                S_TX_WAIT: begin
                    tx_hold <= 1'b0;
                    if (!tx_hold && !tx_busy) begin
                        tx_sr    <= {8'h00, tx_sr[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mem_responder.sv
`timescale 1ns/1ps
module tb_uart_mem_responder;

    localparam int ADDR_W = 16;
    localparam int TO     = 16;
    localparam int TX_LEN = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_fault = 1'b0;
    logic              tx_busy;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              mem_ce, mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;
    logic              frame_err;

    always #5 clk = ~clk;

    uart_mem_responder #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_fault(rx_fault),
        .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .frame_err(frame_err)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    // Synchronous RAM attached to the DUT.
    logic [31:0] ram [logic [15:0]];
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) begin
                logic [31:0] w;
                w = ram.exists(mem_addr) ? ram[mem_addr] : 32'h0;
                for (int k = 0; k < 4; k++) if (mem_be[k]) w[8*k +: 8] = mem_wdata[8*k +: 8];
                ram[mem_addr] = w;
            end else begin
                mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : 32'h0;
            end
        end
    end

    // UART transmitter: busy from the cycle after tx_start for TX_LEN cycles.
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (tx_start)          busy_cnt <= TX_LEN;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt > 0);

    // Observers, sampled on the falling edge.
    int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
    logic [15:0] wr_addr, rd_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic [7:0]  txq [$];
    always @(negedge clk) begin
        if (mem_ce && mem_we)  begin wr_cnt++; wr_addr = mem_addr; wr_be = mem_be; wr_data = mem_wdata; end
        if (mem_ce && !mem_we) begin rd_cnt++; rd_addr = mem_addr; end
        if (frame_err) err_cnt++;
        if (tx_start) begin
            txq.push_back(tx_data);
            check("tx_start_while_busy", {31'b0, tx_busy}, 32'h0);
        end
    end

    function automatic int ack_n();
`ifdef WRITE_ACK_EN
        return 1;
`else
        return 0;
`endif
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic f, input int gap);
        @(posedge clk); #1;
        rx_data = b; rx_valid = 1'b1; rx_fault = f;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_fault = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_frame(input logic [71:0] b, input int n, input int fault_at, input int gap);
        for (int i = 0; i < n; i++) send_byte(b[8*i +: 8], (i == fault_at), gap);
    endtask

    // Wait for n tx bytes since index start, then for the transmitter to go idle.
    task automatic wait_done(input int start, input int n);
        int c;
        c = 0;
        while ((txq.size() - start) < n && c < 400) begin @(negedge clk); c++; end
        repeat (2) @(negedge clk);
        while (tx_busy && c < 400) begin @(negedge clk); c++; end
        repeat (3) @(negedge clk);
        if (c >= 400) begin
            n_total++;
            $display("FAIL wait_done: got %0d tx bytes, expected %0d", txq.size() - start, n);
        end
    endtask

    function automatic logic [31:0] tx_word(input int s);
        return {txq[s+3], txq[s+2], txq[s+1], txq[s]};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_data"},   {24'h0, tx_data},   32'h0);
        check({tag, "_tx_start"},  {31'h0, tx_start},  32'h0);
        check({tag, "_mem_ce"},    {31'h0, mem_ce},    32'h0);
        check({tag, "_mem_we"},    {31'h0, mem_we},    32'h0);
        check({tag, "_mem_be"},    {28'h0, mem_be},    32'h0);
        check({tag, "_mem_addr"},  {16'h0, mem_addr},  32'h0);
        check({tag, "_mem_wdata"}, mem_wdata,          32'h0);
        check({tag, "_frame_err"}, {31'h0, frame_err}, 32'h0);
    endtask

    // Read frame at a byte address, expecting word exp.
    task automatic read_expect(input string tag, input logic [31:0] addr, input int gap, input logic [31:0] exp);
        int s, e0;
        s = txq.size(); e0 = err_cnt;
        send_frame({32'h0, addr, 8'h00}, 5, -1, gap);
        wait_done(s, 4);
        check({tag, "_err"}, err_cnt - e0, 0);
        check({tag, "_ntx"}, txq.size() - s, 4);
        if (txq.size() - s >= 4) check({tag, "_data"}, tx_word(s), exp);
    endtask

    typedef struct {
        logic [71:0] b;        // {data, addr, cmd}, byte 0 = command
        int          n;
        int          fault_at;
        int          exp_wr, exp_rd, exp_err;
        logic [15:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        int          exp_ntx;
        logic [31:0] exp_tx;
    } vec_t;

    logic [31:0] model [int];

    function automatic logic [31:0] mrd(input int idx);
        return model.exists(idx) ? model[idx] : 32'h0;
    endfunction

    initial begin
        vec_t vt [9];
        int   s, w0, r0, e0;

        vt[0] = '{b: {32'hDEADBEEF, 32'h10, 8'h8F}, n: 9, fault_at: -1, exp_wr: 1, exp_rd: 0, exp_err: 0,
                  exp_addr: 16'd4, exp_be: 4'hF, exp_wdata: 32'hDEADBEEF, exp_ntx: ack_n(), exp_tx: 32'hA5};
        vt[1] = '{b: {32'h0, 32'h10, 8'h00}, n: 5, fault_at: -1, exp_wr: 0, exp_rd: 1, exp_err: 0,
                  exp_addr: 16'd4, exp_be: 4'h0, exp_wdata: 32'h0, exp_ntx: 4, exp_tx: 32'hDEADBEEF};
        vt[2] = '{b: {32'h11223344, 32'h08, 8'h83}, n: 9, fault_at: -1, exp_wr: 1, exp_rd: 0, exp_err: 0,
                  exp_addr: 16'd2, exp_be: 4'h3, exp_wdata: 32'h11223344, exp_ntx: ack_n(), exp_tx: 32'hA5};
        vt[3] = '{b: {32'h0, 32'h08, 8'h00}, n: 5, fault_at: -1, exp_wr: 0, exp_rd: 1, exp_err: 0,
                  exp_addr: 16'd2, exp_be: 4'h0, exp_wdata: 32'h0, exp_ntx: 4, exp_tx: 32'hFFFF3344};
        vt[4] = '{b: {64'h0, 8'h70}, n: 1, fault_at: -1, exp_wr: 0, exp_rd: 0, exp_err: 1,
                  exp_addr: 16'd0, exp_be: 4'h0, exp_wdata: 32'h0, exp_ntx: 0, exp_tx: 32'h0};
        vt[5] = '{b: {32'h0, 32'h10, 8'h00}, n: 5, fault_at: -1, exp_wr: 0, exp_rd: 1, exp_err: 0,
                  exp_addr: 16'd4, exp_be: 4'h0, exp_wdata: 32'h0, exp_ntx: 4, exp_tx: 32'hDEADBEEF};
        vt[6] = '{b: {32'h0, 32'h10, 8'h00}, n: 4, fault_at: 3, exp_wr: 0, exp_rd: 0, exp_err: 1,
                  exp_addr: 16'd0, exp_be: 4'h0, exp_wdata: 32'h0, exp_ntx: 0, exp_tx: 32'h0};
        vt[7] = '{b: {32'h12345678, 32'h10, 8'h80}, n: 9, fault_at: -1, exp_wr: 0, exp_rd: 0, exp_err: 0,
                  exp_addr: 16'd0, exp_be: 4'h0, exp_wdata: 32'h0, exp_ntx: ack_n(), exp_tx: 32'hA5};
        vt[8] = '{b: {32'h0, 32'hFFFC0013, 8'h00}, n: 5, fault_at: -1, exp_wr: 0, exp_rd: 1, exp_err: 0,
                  exp_addr: 16'd4, exp_be: 4'h0, exp_wdata: 32'h0, exp_ntx: 4, exp_tx: 32'hDEADBEEF};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        ram[16'd2] = 32'hFFFFFFFF;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            s = txq.size(); w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
            send_frame(vt[i].b, vt[i].n, vt[i].fault_at, 1);
            wait_done(s, vt[i].exp_ntx);
            check($sformatf("v%0d_wr", i),  wr_cnt - w0,      vt[i].exp_wr);
            check($sformatf("v%0d_rd", i),  rd_cnt - r0,      vt[i].exp_rd);
            check($sformatf("v%0d_err", i), err_cnt - e0,     vt[i].exp_err);
            check($sformatf("v%0d_ntx", i), txq.size() - s,   vt[i].exp_ntx);
            if (vt[i].exp_wr != 0) begin
                check($sformatf("v%0d_waddr", i), {16'h0, wr_addr}, {16'h0, vt[i].exp_addr});
                check($sformatf("v%0d_be", i),    {28'h0, wr_be},   {28'h0, vt[i].exp_be});
                check($sformatf("v%0d_wdata", i), wr_data,          vt[i].exp_wdata);
            end
            if (vt[i].exp_rd != 0)
                check($sformatf("v%0d_raddr", i), {16'h0, rd_addr}, {16'h0, vt[i].exp_addr});
            if (vt[i].exp_ntx == 4 && txq.size() - s >= 4)
                check($sformatf("v%0d_rdata", i), tx_word(s), vt[i].exp_tx);
            if (vt[i].exp_ntx == 1 && txq.size() - s >= 1)
                check($sformatf("v%0d_ack", i), {24'h0, txq[s]}, vt[i].exp_tx);
        end

        // Inter-byte timeout after A1
        r0 = rd_cnt; e0 = err_cnt;
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h10, 1'b0, 0);
        send_byte(8'h00, 1'b0, 20);
        check("timeout_err", err_cnt - e0, 1);
        check("timeout_no_rd", rd_cnt - r0, 0);
        read_expect("after_timeout", 32'h10, 1, 32'hDEADBEEF);

        // Gap just under the timeout is tolerated
        read_expect("slow_gap", 32'h10, 12, 32'hDEADBEEF);

        // A byte arriving during the response must not start a frame
        s = txq.size();
        send_frame({32'h0, 32'h08, 8'h00}, 5, -1, 1);
        for (int c = 0; c < 100 && txq.size() == s; c++) @(negedge clk);
        send_byte(8'h00, 1'b0, 0);
        wait_done(s, 4);
        check("stray_ntx", txq.size() - s, 4);
        if (txq.size() - s >= 4) check("stray_data", tx_word(s), 32'hFFFF3344);
        w0 = wr_cnt; s = txq.size();
        send_frame({32'hCAFEF00D, 32'h20, 8'h8F}, 9, -1, 1);
        wait_done(s, ack_n());
        check("stray_wr", wr_cnt - w0, 1);
        check("stray_waddr", {16'h0, wr_addr}, 32'd8);
        check("stray_wdata", wr_data, 32'hCAFEF00D);

        // Reset during TX_WAIT of byte 2
        s = txq.size();
        send_frame({32'h0, 32'h10, 8'h00}, 5, -1, 1);
        for (int c = 0; c < 200 && (txq.size() - s) < 2; c++) @(negedge clk);
        check("pre_rst_ntx", txq.size() - s, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        check_reset_outputs("midtx_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 50 && tx_busy; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("rst_dropped_tx", txq.size() - s, 2);
        read_expect("after_rst", 32'h10, 1, 32'hDEADBEEF);

        // Randomized frames against a word-level model of memory
        ram.delete();
        model.delete();
        for (int t = 0; t < 40; t++) begin
            int          kind, idx;
            logic [31:0] addr, data;
            logic [3:0]  be;
            logic [7:0]  cmd;
            kind = $urandom_range(0, 9);
            idx  = $urandom_range(0, 7);
            addr = ($urandom() & 32'hFFFC0000) | (idx << 2) | $urandom_range(0, 3);
            s = txq.size(); w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
            if (kind < 5) begin
                logic [31:0] m;
                be   = 4'($urandom_range(0, 15));
                data = $urandom();
                send_frame({data, addr, {4'h8, be}}, 9, -1, $urandom_range(0, 3));
                wait_done(s, ack_n());
                m = mrd(idx);
                for (int k = 0; k < 4; k++) if (be[k]) m[8*k +: 8] = data[8*k +: 8];
                model[idx] = m;
                check($sformatf("rnd%0d_wr", t), wr_cnt - w0, (be != 0) ? 1 : 0);
                if (be != 0) begin
                    check($sformatf("rnd%0d_waddr", t), {16'h0, wr_addr}, idx);
                    check($sformatf("rnd%0d_be", t), {28'h0, wr_be}, {28'h0, be});
                    check($sformatf("rnd%0d_wdata", t), wr_data, data);
                end
            end else if (kind < 9) begin
                send_frame({32'h0, addr, 8'h00}, 5, -1, $urandom_range(0, 3));
                wait_done(s, 4);
                check($sformatf("rnd%0d_rd", t), rd_cnt - r0, 1);
                check($sformatf("rnd%0d_raddr", t), {16'h0, rd_addr}, idx);
                check($sformatf("rnd%0d_ntx", t), txq.size() - s, 4);
                if (txq.size() - s >= 4) check($sformatf("rnd%0d_rdata", t), tx_word(s), mrd(idx));
            end else begin
                cmd = 8'($urandom_range(0, 255)) | 8'h20;
                send_byte(cmd, 1'b0, 2);
                repeat (3) @(negedge clk);
                check($sformatf("rnd%0d_rsv_err", t), err_cnt - e0, 1);
                check($sformatf("rnd%0d_rsv_noacc", t), (wr_cnt - w0) + (rd_cnt - r0), 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_mem_responder.md
Name: uart_mem_responder

Overview:
- Memory-side end of the CPU's UART memory link.
- Receives command frames byte-by-byte from a UART receiver, decodes them, and performs word reads/writes on a synchronous 32-bit RAM.
- Streams read data back through a UART transmitter.
- Sits between uart_rx/uart_tx and the instruction/data RAM on the host board.

Parameters:
- ADDR_W, 16, word-address width driven to RAM (RAM depth = 2^ADDR_W words).
- TIMEOUT_CYCLES, 1000000, max idle clocks between bytes of one frame before the frame is aborted.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- rx_data  input  8  received byte, valid when rx_valid=1
- rx_valid  input  1  one-cycle strobe per received byte
- rx_fault  input  1  framing/parity error qualifier for the current rx_valid
- tx_busy  input  1  transmitter busy; rises the cycle after tx_start, stays high until byte sent
- tx_data  output  8  byte to transmit, held stable while tx_busy=1
- tx_start  output  1  one-cycle request to send tx_data
- mem_ce  output  1  RAM access enable, one-cycle pulse
- mem_we  output  1  RAM write enable, qualified by mem_ce
- mem_be  output  4  byte enables for writes
- mem_addr  output  ADDR_W  word address = frame byte address [ADDR_W+1:2]
- mem_wdata  output  32  write data
- mem_rdata  input  32  read data, valid exactly one cycle after mem_ce with mem_we=0
- frame_err  output  1  one-cycle pulse on any frame abort

Behaviour:
- Frame format; all multi-byte fields LSB first:
  - Command byte C: C[7]=1 write, 0 read; C[6:4] reserved, must be 0; C[3:0] byte enables, ignored for reads.
  - Read frame: C, A0..A3. Response: D0..D3 of the RAM word.
  - Write frame: C, A0..A3, D0..D3. No response.
- Reset values: tx_data=0, tx_start=0, mem_ce=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, frame_err=0, state=IDLE, all counters 0.
- States:
  - IDLE: wait for a byte. C[6:4]!=0 -> frame_err pulse, stay IDLE. Otherwise latch C, go ADDR.
  - ADDR: collect 4 bytes (2-bit counter). After A3: write -> DATA; read -> MEM_RD.
  - DATA: collect 4 bytes. After D3 -> MEM_WR.
  - MEM_WR: one cycle.
    - mem_ce=1, mem_we=1, mem_be=C[3:0], mem_addr, mem_wdata driven.
    - If C[3:0]=0, mem_ce stays 0 and no RAM write occurs.
    - Next state IDLE.
  - MEM_RD: one cycle, mem_ce=1, mem_we=0 -> RD_WAIT.
  - RD_WAIT: latch mem_rdata into a 32-bit shift register -> SEND.
  - SEND: when tx_busy=0, drive tx_data=low byte and pulse tx_start -> TX_WAIT.
  - TX_WAIT: ignore tx_busy for one cycle, then wait for tx_busy=0. Shift register >>8, byte count +1. After 4th byte -> IDLE, else -> SEND.
- Latency: RAM read issued the cycle after A3 is accepted. First tx_start no earlier than 3 cycles after the A3 rx_valid.
- rx_valid with rx_fault=1 in any receive state: byte discarded, frame_err pulse, -> IDLE. In IDLE it is just discarded, with a frame_err pulse.
- Inter-byte timeout: counter runs in ADDR/DATA, clears on each accepted byte. Reaching TIMEOUT_CYCLES-1 -> frame_err pulse, -> IDLE, no RAM access.
- rx_valid during MEM_*, RD_WAIT, SEND, TX_WAIT: byte dropped; it is not counted toward the next frame.
- Address bits above ADDR_W+1 and bits [1:0] are ignored (wrap-around aliasing).
- Async rst mid-frame or mid-transmit returns to IDLE immediately. A tx_start pulse in flight is dropped.

Optional Feature:
- WRITE_ACK_EN defined: after MEM_WR the FSM enters SEND with a single byte 0xA5, C[3:0]=0 included, then returns to IDLE after that byte completes.
- Undefined: write frames produce no tx activity.

Test Plan:
- Write frame 0x8F,0x10,0x00,0x00,0x00,0xEF,0xBE,0xAD,0xDE -> one mem_ce/mem_we pulse, mem_addr=4, mem_be=F, mem_wdata=0xDEADBEEF; no tx_start.
- Read frame 0x00,0x10,0x00,0x00,0x00 with RAM[4]=0xDEADBEEF -> one read pulse at addr 4; tx bytes EF,BE,AD,DE in order, each tx_start only while tx_busy=0.
- Partial write 0x83 to addr 0x08 with data 0x11223344 -> mem_be=3, mem_addr=2; read back with RAM preloaded 0xFFFFFFFF returns 44,33,FF,FF.
- Command 0x70 -> frame_err pulse; a following valid read frame completes normally.
- Faults and timeouts:
  - rx_fault on A2 -> frame_err, no mem_ce.
  - TIMEOUT_CYCLES=16 with a gap of 20 cycles after A1 -> frame_err, IDLE.
- Assert rst during TX_WAIT of byte 2 -> all outputs at reset values; the next read frame returns all 4 bytes.
